// File: rtl/spi_slave_param_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_param_if
// Description : Signal bundle between the SPI slave front-end and the
//               environment that drives it.
//               slave  modport : ss_n, mosi, tx_valid, tx_data in;
//                                rx_data, rx_valid, miso, err, busy out.
//               master modport : the mirror image, used by whoever drives
//                                the SPI pins and the RAM read-data path.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic              miso;
    logic              err;
    logic              busy;

    modport slave (
        input  ss_n, mosi, tx_valid, tx_data,
        output rx_data, rx_valid, miso, err, busy
    );

    modport master (
        output ss_n, mosi, tx_valid, tx_data,
        input  rx_data, rx_valid, miso, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_param
// Description : SPI slave front-end for the single-port RAM path. Receives
//               one (DATA_W+2)-bit command frame per ss_n low period, MSB
//               first, and presents it on rx_data with a one-cycle rx_valid.
//               For read-data frames it then waits for the RAM read data
//               and shifts it out on miso, MSB first. Flags frame aborts,
//               read command sequence violations and read timeouts on err.
// Ports       : clk            - system clock, SPI pins sampled on rising edge
//               rst            - asynchronous active-high reset
//               bus (slave)    - ss_n, mosi, tx_valid, tx_data in;
//                                rx_data, rx_valid, miso, err, busy out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_param_if.slave  bus
);

    localparam int FW    = DATA_W + 2;
    localparam int CNT_W = $clog2(FW);
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
    localparam int SH_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] LAST_BIT_CNT = CNT_W'(FW - 2);
    localparam logic [TO_W-1:0]  LAST_WAIT    = TO_W'(RD_TIMEOUT - 1);
    localparam logic [SH_W-1:0]  SH_LOAD      = SH_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_t;

    // Sub-phase of READ_DATA once the command frame has been accepted.
    typedef enum logic [1:0] {
        RD_WAIT  = 2'd0,
        RD_SHIFT = 2'd1,
        RD_DONE  = 2'd2
    } rd_phase_t;

    state_t            state_q,        state_d;
    rd_phase_t         rd_phase_q,     rd_phase_d;
    logic [FW-2:0]     rx_sr_q,        rx_sr_d;
    logic [CNT_W-1:0]  bit_cnt_q,      bit_cnt_d;
    logic              frame_done_q,   frame_done_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic [TO_W-1:0]   wait_cnt_q,     wait_cnt_d;
    logic [DATA_W-1:0] tx_sr_q,        tx_sr_d;
    logic [SH_W-1:0]   sh_cnt_q,       sh_cnt_d;
    logic [FW-1:0]     rx_data_q,      rx_data_d;
    logic              rx_valid_q,     rx_valid_d;
    logic              miso_q,         miso_d;
    logic              err_q,          err_d;
    logic              busy_q,         busy_d;

    // Complete frame as it stands on the edge that samples bit 0.
    logic [FW-1:0] w_frame;
    logic          w_cmd_ok;

    assign w_frame = {rx_sr_q, bus.mosi};

    // The first command bit already steered the state, so only the second
    // bit distinguishes a legal read frame from a sequence violation.
    always_comb begin
        w_cmd_ok = 1'b0;
        case (state_q)
            ST_WRITE:     w_cmd_ok = 1'b1;
            ST_READ_ADD:  w_cmd_ok = (w_frame[FW-1:FW-2] == 2'b10);
            ST_READ_DATA: w_cmd_ok = (w_frame[FW-1:FW-2] == 2'b11);
            default:      w_cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        rd_phase_d     = rd_phase_q;
        rx_sr_d        = rx_sr_q;
        bit_cnt_d      = bit_cnt_q;
        frame_done_d   = frame_done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        wait_cnt_d     = wait_cnt_q;
        tx_sr_d        = tx_sr_q;
        sh_cnt_d       = sh_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        err_d          = 1'b0;

        if (state_q != ST_IDLE && bus.ss_n) begin
            // Deselect always wins. It is only an error if the frame was
            // still incomplete; abandoning a miso shift is silent.
            state_d    = ST_IDLE;
            rd_phase_d = RD_DONE;
            miso_d     = 1'b0;
            err_d      = !frame_done_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rx_sr_d      = '0;
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b0;
                    rd_phase_d   = RD_DONE;
                    wait_cnt_d   = '0;
                    miso_d       = 1'b0;
                    if (!bus.ss_n) begin
                        state_d = ST_CHK_CMD;
                    end
                end

                ST_CHK_CMD: begin
                    rx_sr_d   = {{(FW-2){1'b0}}, bus.mosi};
                    bit_cnt_d = '0;
                    if (!bus.mosi) begin
                        state_d = ST_WRITE;
                    end else if (!rd_addr_seen_q) begin
                        state_d = ST_READ_ADD;
                    end else begin
                        state_d = ST_READ_DATA;
                    end
                end

                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (!frame_done_q) begin
                        rx_sr_d   = w_frame[FW-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT_CNT) begin
                            frame_done_d = 1'b1;
                            if (w_cmd_ok) begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = w_frame;
                                if (state_q == ST_READ_ADD) begin
                                    rd_addr_seen_d = 1'b1;
                                end
                                if (state_q == ST_READ_DATA) begin
                                    rd_addr_seen_d = 1'b0;
                                    rd_phase_d     = RD_WAIT;
                                    wait_cnt_d     = '0;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (state_q == ST_READ_DATA) begin
                        case (rd_phase_q)
                            RD_WAIT: begin
                                if (bus.tx_valid) begin
                                    // MSB goes out immediately; the rest
                                    // is held left-aligned in tx_sr.
                                    miso_d     = bus.tx_data[DATA_W-1];
                                    tx_sr_d    = bus.tx_data << 1;
                                    sh_cnt_d   = SH_LOAD;
                                    rd_phase_d = RD_SHIFT;
                                end else if (wait_cnt_q == LAST_WAIT) begin
                                    err_d      = 1'b1;
                                    miso_d     = 1'b0;
                                    rd_phase_d = RD_DONE;
                                end else begin
                                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                                end
                            end
                            RD_SHIFT: begin
                                if (sh_cnt_q == '0) begin
                                    miso_d     = 1'b0;
                                    rd_phase_d = RD_DONE;
                                end else begin
                                    miso_d   = tx_sr_q[DATA_W-1];
                                    tx_sr_d  = tx_sr_q << 1;
                                    sh_cnt_d = sh_cnt_q - SH_W'(1);
                                end
                            end
                            default: begin
                                miso_d = 1'b0;
                            end
                        endcase
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rd_phase_q     <= RD_DONE;
            rx_sr_q        <= '0;
            bit_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            wait_cnt_q     <= '0;
            tx_sr_q        <= '0;
            sh_cnt_q       <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_phase_q     <= rd_phase_d;
            rx_sr_q        <= rx_sr_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_done_q   <= frame_done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            wait_cnt_q     <= wait_cnt_d;
            tx_sr_q        <= tx_sr_d;
            sh_cnt_q       <= sh_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.miso     = miso_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_param
// Description : Self-checking bench for spi_slave_param (DATA_W=8,
//               RD_TIMEOUT=16). Expected frames and error pulses are queued
//               with their expected cycle stamps as stimulus is driven; a
//               negedge monitor queues what the DUT actually produced.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave_param;

    localparam int DATA_W     = 8;
    localparam int RD_TIMEOUT = 16;
    localparam int FW         = DATA_W + 2;

    typedef struct {
        logic [FW-1:0] data;
        int            cyc;
    } rx_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   both_cnt = 0;

    rx_ev_t rx_exp_q[$];
    rx_ev_t rx_obs_q[$];
    int     err_exp_q[$];
    int     err_obs_q[$];
    logic   miso_exp_q[$];

    spi_slave_param_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_param #(
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every rx_valid / err pulse with its cycle.
    always @(negedge clk) begin
        rx_ev_t ev;
        if (bus.rx_valid === 1'b1) begin
            ev.data = bus.rx_data;
            ev.cyc  = cyc;
            rx_obs_q.push_back(ev);
        end
        if (bus.err === 1'b1) err_obs_q.push_back(cyc);
        if (bus.rx_valid === 1'b1 && bus.err === 1'b1) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic start_frame(output int t_edge0);
        @(negedge clk);
        bus.ss_n = 1'b0;
        t_edge0  = cyc + 1;
    endtask

    task automatic drive_bits(input logic [FW-1:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.mosi = f[FW-1-i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.ss_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_rx(input logic [FW-1:0] d, input int c);
        rx_ev_t ev;
        ev.data = d;
        ev.cyc  = c;
        rx_exp_q.push_back(ev);
    endtask

    // Full frame sent as its own ss_n period; rx expected FW edges after ss_n low.
    task automatic send_good(input logic [FW-1:0] f);
        int t;
        start_frame(t);
        push_rx(f, t + FW);
        drive_bits(f, FW);
        end_frame();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data); end
        checks++;
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        checks++;
        if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int t;
        rx_ev_t e, o;
        start_frame(t);
        push_rx(10'h0A5, t + FW);
        drive_bits(10'h0A5, FW);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", bus.busy); end
        end_frame();
        // Second frame, followed by surplus bits that must be ignored.
        start_frame(t);
        push_rx(10'h13C, t + FW);
        drive_bits(10'h13C, FW);
        drive_bits(10'h3FF, 5);
        end_frame();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_idle_busy: got %b expected 0", bus.busy); end
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL write_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL write_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL write_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    task automatic test_read();
        int t, miso_bad;
        logic exp_bit;
        rx_ev_t e, o;
        // tx_valid while idle must not reach miso.
        @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
        @(negedge clk); bus.tx_valid = 1'b0;
        miso_bad = 0;
        repeat (3) begin @(negedge clk); if (bus.miso !== 1'b0) miso_bad++; end
        checks++;
        if (miso_bad != 0) begin errors++; $display("FAIL idle_tx_ignored: got %0d miso highs expected 0", miso_bad); end

        send_good(10'h207);
        start_frame(t);
        push_rx(10'h35A, t + FW);
        drive_bits(10'h35A, FW);
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hC3;
        for (int i = DATA_W - 1; i >= 0; i--) miso_exp_q.push_back(bus.tx_data[i]);
        for (int i = 0; i < DATA_W; i++) begin
            @(negedge clk);
            bus.tx_valid = (i == 2);
            if (i == 2) bus.tx_data = 8'h00;
            exp_bit = miso_exp_q.pop_front();
            checks++;
            if (bus.miso !== exp_bit) begin errors++; $display("FAIL read_miso_bit%0d: got %b expected %b", i, bus.miso, exp_bit); end
        end
        bus.tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.miso !== 1'b0) begin errors++; $display("FAIL read_miso_tail: got %b expected 0", bus.miso); end
        end_frame();
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL read_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL read_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL read_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    task automatic test_seq_err();
        int t, ec, oc;
        rx_ev_t e, o;
        // rd_addr_seen was cleared by the read, so this is a legal rd-addr.
        send_good(10'h2F0);
        // Now in READ_DATA territory with cmd 10: sequence violation.
        start_frame(t);
        err_exp_q.push_back(t + FW);
        drive_bits(10'h20F, FW);
        end_frame();
        // rd_addr_seen must have survived the violation.
        send_good(10'h3C3);
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL seq_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL seq_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        while (err_exp_q.size() > 0) begin
            ec = err_exp_q.pop_front();
            checks++;
            if (err_obs_q.size() == 0) begin
                errors++; $display("FAIL seq_err: got none expected err at cycle %0d", ec);
            end else begin
                oc = err_obs_q.pop_front();
                if (oc != ec) begin errors++; $display("FAIL seq_err: got err at cycle %0d expected cycle %0d", oc, ec); end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL seq_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    task automatic test_abort();
        int t, ec, oc;
        rx_ev_t e, o;
        // Write frame abandoned after 5 bits; ss_n high seen on edge 6.
        start_frame(t);
        err_exp_q.push_back(t + 6);
        drive_bits(10'h0F0, 5);
        end_frame();
        send_good(10'h0F0);
        // Abort of a rd-data frame must keep rd_addr_seen set.
        send_good(10'h255);
        start_frame(t);
        err_exp_q.push_back(t + 5);
        drive_bits(10'h3FF, 4);
        end_frame();
        send_good(10'h3AA);
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL abort_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL abort_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        while (err_exp_q.size() > 0) begin
            ec = err_exp_q.pop_front();
            checks++;
            if (err_obs_q.size() == 0) begin
                errors++; $display("FAIL abort_err: got none expected err at cycle %0d", ec);
            end else begin
                oc = err_obs_q.pop_front();
                if (oc != ec) begin errors++; $display("FAIL abort_err: got err at cycle %0d expected cycle %0d", oc, ec); end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL abort_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    task automatic test_timeout();
        int t, ec, oc, miso_bad;
        rx_ev_t e, o;
        send_good(10'h2AA);
        start_frame(t);
        push_rx(10'h301, t + FW);
        err_exp_q.push_back(t + FW + RD_TIMEOUT);
        drive_bits(10'h301, FW);
        miso_bad = 0;
        for (int i = 0; i < RD_TIMEOUT + 4; i++) begin
            @(negedge clk);
            // Late tx_valid after the timeout must be ignored.
            bus.tx_valid = (i == RD_TIMEOUT + 2);
            bus.tx_data  = 8'hFF;
            if (bus.miso !== 1'b0) miso_bad++;
        end
        bus.tx_valid = 1'b0;
        @(negedge clk);
        if (bus.miso !== 1'b0) miso_bad++;
        checks++;
        if (miso_bad != 0) begin errors++; $display("FAIL timeout_miso: got %0d miso highs expected 0", miso_bad); end
        end_frame();
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL timeout_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL timeout_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        while (err_exp_q.size() > 0) begin
            ec = err_exp_q.pop_front();
            checks++;
            if (err_obs_q.size() == 0) begin
                errors++; $display("FAIL timeout_err: got none expected err at cycle %0d", ec);
            end else begin
                oc = err_obs_q.pop_front();
                if (oc != ec) begin errors++; $display("FAIL timeout_err: got err at cycle %0d expected cycle %0d", oc, ec); end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL timeout_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    task automatic test_rst_mid();
        int t;
        rx_ev_t e, o;
        // Reset part-way through a write frame.
        start_frame(t);
        drive_bits(10'h0A5, 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_data !== '0) begin
            errors++; $display("FAIL rst_mid_write: got busy=%b rx_data=%h expected busy=0 rx_data=000", bus.busy, bus.rx_data);
        end
        bus.ss_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        send_good(10'h13C);
        // Reset part-way through a miso shift.
        send_good(10'h200);
        start_frame(t);
        push_rx(10'h3FF, t + FW);
        drive_bits(10'h3FF, FW);
        @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
        @(negedge clk); bus.tx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.miso !== 1'b1) begin errors++; $display("FAIL rst_pre_shift_miso: got %b expected 1", bus.miso); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.miso !== 1'b0 || bus.busy !== 1'b0 || bus.rx_data !== '0) begin
            errors++; $display("FAIL rst_mid_shift: got miso=%b busy=%b rx_data=%h expected 0 0 000", bus.miso, bus.busy, bus.rx_data);
        end
        bus.ss_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        // rd_addr_seen was reset, so a cmd-10 frame is a legal rd-addr again.
        send_good(10'h2A5);
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_obs_q.size() == 0) begin
                errors++; $display("FAIL rst_rx: got none expected %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = rx_obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    errors++; $display("FAIL rst_rx: got %h at cycle %0d expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (rx_obs_q.size() != 0 || err_obs_q.size() != 0) begin
            errors++; $display("FAIL rst_extra: got %0d rx and %0d err extra, expected 0", rx_obs_q.size(), err_obs_q.size());
            rx_obs_q.delete(); err_obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_seq_err();
        test_abort();
        test_timeout();
        test_rst_mid();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL err_rx_overlap: got %0d overlapping cycles expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
